// File: rtl/seq_bin_to_bcd.sv
// ---------------------------------------------------------------------------
// seq_bin_to_bcd
//   Sequential binary-to-BCD converter (double dabble, one bit per clock).
//   Takes an unsigned or two's-complement word, converts its magnitude to
//   DIGITS packed BCD digits and reports sign plus a sticky overflow when the
//   magnitude does not fit in DIGITS decimal digits.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid / in_ready  operand handshake (in_ready only in IDLE)
//   bin                  binary operand, sampled on the acceptance edge
//   out_valid/out_ready  result handshake (out_valid only in DONE)
//   bcd                  packed BCD, digit k at [4k+3:4k], digit 0 = LSD
//   sign                 operand was negative (always 0 when SIGNED=0)
//   overflow             magnitude >= 10^DIGITS, bcd = magnitude mod 10^DIGITS
// ---------------------------------------------------------------------------

// Per-digit double-dabble correction: digits of 5..9 get +3 so that the
// following left shift carries into the next decade. 4-bit wrap is intended.
module bcd_dab_digit (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);
  assign d_o = (d_i >= 4'd5) ? (d_i + 4'd3) : d_i;
endmodule

module seq_bin_to_bcd #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5,
  parameter int SIGNED = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  sign,
  output logic                  overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [BIN_W-1:0] BIN_ONE  = {{(BIN_W-1){1'b0}}, 1'b1};

  // state
  logic [1:0]        state_q,    state_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic [BIN_W-1:0]  mag_q,      mag_d;
  logic [BCD_W-1:0]  work_q,     work_d;
  logic              wsign_q,    wsign_d;
  logic              wovf_q,     wovf_d;
  logic [BCD_W-1:0]  bcd_q,      bcd_d;
  logic              sign_q,     sign_d;
  logic              ovf_q,      ovf_d;

  // datapath helpers
  logic [DIGITS-1:0][3:0] adj;
  logic [BCD_W-1:0]       adj_flat;
  logic [BCD_W-1:0]       work_sh;
  logic                   carry_out;
  logic [BIN_W-1:0]       bin_neg;
  logic                   bin_is_neg;

  // Correction stage, one instance per BCD digit.
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_dab_digit u_dig (
      .d_i (work_q[4*g +: 4]),
      .d_o (adj[g])
    );
  end

  assign adj_flat  = adj;
  // Shift {adjusted work, mag} left by one: the MSB of mag enters digit 0,
  // the top bit of the BCD register falls out and feeds the sticky overflow.
  assign carry_out = adj_flat[BCD_W-1];
  assign work_sh   = {adj_flat[BCD_W-2:0], mag_q[BIN_W-1]};

  // Two's-complement magnitude. For the most-negative value the truncated
  // result is 2^(BIN_W-1), which is the correct unsigned magnitude.
  assign bin_neg    = ~bin + BIN_ONE;
  assign bin_is_neg = (SIGNED != 0) && bin[BIN_W-1];

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign bcd       = bcd_q;
  assign sign      = sign_q;
  assign overflow  = ovf_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    work_d  = work_q;
    wsign_d = wsign_q;
    wovf_d  = wovf_q;
    bcd_d   = bcd_q;
    sign_d  = sign_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_CONV;
          cnt_d   = CNT_LOAD;
          mag_d   = bin_is_neg ? bin_neg : bin;
          work_d  = '0;
          wsign_d = bin_is_neg;
          wovf_d  = 1'b0;
        end
      end

      S_CONV: begin
        work_d = work_sh;
        mag_d  = {mag_q[BIN_W-2:0], 1'b0};
        wovf_d = wovf_q | carry_out;
        cnt_d  = cnt_q - CNT_ONE;
        // Last bit: publish straight from the step result so the output
        // registers change exactly once per conversion.
        if (cnt_q == CNT_ONE) begin
          state_d = S_DONE;
          bcd_d   = work_sh;
          sign_d  = wsign_q;
          ovf_d   = wovf_q | carry_out;
        end
      end

      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mag_q   <= '0;
      work_q  <= '0;
      wsign_q <= 1'b0;
      wovf_q  <= 1'b0;
      bcd_q   <= '0;
      sign_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mag_q   <= mag_d;
      work_q  <= work_d;
      wsign_q <= wsign_d;
      wovf_q  <= wovf_d;
      bcd_q   <= bcd_d;
      sign_q  <= sign_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
